// File: rtl/serial_and_reducer_if.sv
// Stream bundle for serial_and_reducer: one-bit beat input stream and a
// frame-result output stream, both valid/ready.
interface serial_and_reducer_if #(
   parameter int unsigned LEN_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic             out_and;
   logic             out_any;
   logic [LEN_W-1:0] out_len;
   logic             out_ovf;

   // Environment side: produces beats, consumes results.
   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_and, out_any, out_len, out_ovf
   );

   // Reducer side.
   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_and, out_any, out_len, out_ovf
   );
endinterface

// File: rtl/serial_and_reducer.sv
// Groups a one-bit valid/ready stream into in_last-delimited frames and emits
// per-frame AND, OR, saturating length and overflow flag on a registered output.
module serial_and_reducer #(
   parameter int unsigned LEN_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   serial_and_reducer_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StAccum} state_e;

   state_e           state_q, state_d;
   logic             acc_and_q, acc_any_q, acc_ovf_q;
   logic [LEN_W-1:0] acc_len_q;
   logic             nxt_and, nxt_any, nxt_ovf;
   logic [LEN_W-1:0] nxt_len;
   logic             out_valid_q, out_and_q, out_any_q, out_ovf_q;
   logic [LEN_W-1:0] out_len_q;
   logic             in_ready;
   logic             beat;
   logic             take;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign beat     = bus.in_valid && in_ready;
   assign take     = out_valid_q && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (beat) begin
         state_d = bus.in_last ? StIdle : StAccum;
      end
   end

   // Accumulator values including the beat offered this cycle.
   always_comb begin
      nxt_and = bus.in_bit;
      nxt_any = bus.in_bit;
      nxt_len = LEN_W'(1);
      nxt_ovf = 1'b0;
      if (state_q == StAccum) begin
         nxt_and = acc_and_q & bus.in_bit;
         nxt_any = acc_any_q | bus.in_bit;
         if (&acc_len_q) begin
            nxt_len = acc_len_q;
            nxt_ovf = 1'b1;
         end else begin
            nxt_len = acc_len_q + 1'b1;
            nxt_ovf = acc_ovf_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_and_q <= 1'b0;
         acc_any_q <= 1'b0;
         acc_len_q <= '0;
         acc_ovf_q <= 1'b0;
      end else if (beat) begin
         acc_and_q <= nxt_and;
         acc_any_q <= nxt_any;
         acc_len_q <= nxt_len;
         acc_ovf_q <= nxt_ovf;
      end
   end

   // A new final beat wins over consumption so back-to-back frames keep valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_and_q   <= 1'b0;
         out_any_q   <= 1'b0;
         out_len_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else if (beat && bus.in_last) begin
         out_valid_q <= 1'b1;
         out_and_q   <= nxt_and;
         out_any_q   <= nxt_any;
         out_len_q   <= nxt_len;
         out_ovf_q   <= nxt_ovf;
      end else if (take) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_and   = out_and_q;
   assign bus.out_any   = out_any_q;
   assign bus.out_len   = out_len_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule

// File: doc/serial_and_reducer.md
# serial_and_reducer

Frame-level reducer placed directly downstream of the bit-level AND gate stage. It consumes the gate's one-bit result as a valid/ready stream and groups the bits into frames delimited by `in_last`. For each frame it produces one result: the AND and the OR of all bits in the frame, plus the frame length with a saturation flag. The result is held on a valid/ready output until it is consumed.

## Interface
- `LEN_W`, default 8: width of the frame-length counter; the maximum countable length is 2^LEN_W − 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an input beat is present.
- `in_ready` output 1: the block can accept a beat this cycle.
- `in_bit` input 1: data bit, i.e. the upstream gate output.
- `in_last` input 1: this beat is the final beat of the frame.
- `out_valid` output 1: a frame result is available.
- `out_ready` input 1: the consumer accepts the result.
- `out_and` output 1: AND of all bits in the frame.
- `out_any` output 1: OR of all bits in the frame.
- `out_len` output LEN_W: number of beats in the frame, saturating.
- `out_ovf` output 1: the frame had more than 2^LEN_W − 1 beats.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- A result is consumed when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and has no dependence on `in_valid`.
- Internal state is `busy` plus the accumulators `acc_and`, `acc_any`, `acc_len` and `acc_ovf`.
- Two-state FSM:
  - IDLE (`busy` = 0) → ACCUM on an accepted beat without `in_last`.
  - ACCUM → IDLE on an accepted beat with `in_last`.
  - In both states, an accepted `in_last` beat loads the output register.
- First beat of a frame (IDLE): `acc_and = in_bit`, `acc_any = in_bit`, `acc_len = 1`, `acc_ovf = 0`.
- Subsequent beats (ACCUM):
  - `acc_and &= in_bit`, `acc_any |= in_bit`.
  - `acc_len` increments. At all-ones it holds and `acc_ovf` sets; `acc_ovf` is sticky until the frame ends.
- Accepted `in_last` beat: the output register captures the final values, including the contribution of that beat, and `out_valid` is set on the next edge.
- A single-beat frame (IDLE plus `in_last`) gives `out_len = 1`, `out_and = out_any = in_bit`.
- Output register behaviour:
  - Holds `out_and`, `out_any`, `out_len` and `out_ovf` stable while `out_valid && !out_ready`.
  - On consumption without a new `in_last` beat in the same cycle, `out_valid` clears. The data fields keep their last values; they are don't-care while `out_valid` = 0.
- Consumption and a new `in_last` beat in the same cycle: the output reloads with the new frame and `out_valid` stays 1. Back-to-back frames sustain one result per cycle.
- Input beats that arrive while the output is blocked are back-pressured, not dropped. Accumulation of a frame in progress pauses.
- Beats with `in_valid` = 0 have no effect. `in_bit` and `in_last` are ignored unless a beat is accepted.

## Timing
- Reset (asynchronous, immediate):
  - `out_valid` = 0, `out_and` = 0, `out_any` = 0, `out_len` = 0, `out_ovf` = 0.
  - `busy` = 0 and all accumulators cleared.
  - `in_ready` = 1 while `rst` is high or immediately after it.
- Reset mid-frame or while a result is pending discards all state. The first accepted beat after reset starts a new frame.
- Latency: an `in_last` beat accepted at edge N gives `out_valid` = 1 after edge N.
- Throughput: one beat per cycle on input; one result per cycle on output when `out_ready` is held high.
- There is no combinational path from `in_valid`, `in_bit` or `in_last` to any output. The only combinational path is `out_ready` → `in_ready`.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs 0 and `in_ready` = 1 at once. Apply reset mid-frame after 3 beats, then send a 2-beat frame {1,1} → `out_len` = 2, `out_and` = 1.
- **Basic frames** (with `out_ready` = 1):
  - Frame {1,1,1,1} → `out_and` = 1, `out_any` = 1, `out_len` = 4, `out_ovf` = 0, `out_valid` 1 cycle after the last beat.
  - Frame {0,0,1} → `out_and` = 0, `out_any` = 1, `out_len` = 3.
  - Single beat {0} with `in_last` → `out_and` = `out_any` = 0, `out_len` = 1.
- **Backpressure:** with `out_ready` = 0, finish frame {1,0} and then offer a new frame → `in_ready` = 0. Outputs hold `out_any` = 1, `out_and` = 0, `out_len` = 2 for 5 cycles. Raise `out_ready` → result consumed and the next frame accepted in the same cycle.
- **Back-to-back:** continuous single-beat frames 1,0,1,1 with `out_ready` = 1 → `out_valid` stays high for 4 consecutive cycles and `out_and` sequence is 1,0,1,1.
- **Saturation** (`LEN_W` = 3): a 9-beat all-ones frame → `out_len` = 7, `out_ovf` = 1, `out_and` = 1. The next 2-beat frame → `out_ovf` = 0, `out_len` = 2.
- **Gaps:** a 3-beat frame with `in_valid` = 0 bubbles between beats and random `in_bit` and `in_last` during the bubbles → result identical to the gap-free case.
